// File: rtl/kmeans_kn_core.sv
// Iterative K-cluster, 2-D k-means engine: classify, accumulate, divide, update.
// Optional macro KMEANS_CONV_EN enables early stop when no centroid changes.
`timescale 1ns/1ps
module kmeans_kn_core #(
  parameter int K                    = 4,
  parameter int data_width           = 8,
  parameter int n_input_data_b_depth = 8,
  parameter int acc_sum_width        = 16,
  parameter int max_iter             = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            ld_valid,
  input  logic [2:0]                      ld_idx,
  input  logic [data_width-1:0]           ld_d0,
  input  logic [data_width-1:0]           ld_d1,
  output logic [n_input_data_b_depth-1:0] data_addr,
  input  logic [data_width-1:0]           d0_in,
  input  logic [data_width-1:0]           d1_in,
  input  logic [2:0]                      rd_idx,
  output logic [data_width-1:0]           c_d0,
  output logic [data_width-1:0]           c_d1,
  output logic                            busy,
  output logic                            done,
  output logic                            converged,
  output logic [7:0]                      iter_count,
  output logic [2:0]                      state_dbg
);
  localparam int DW  = data_width;
  localparam int AW  = n_input_data_b_depth;
  localparam int SW  = acc_sum_width;
  localparam int CW  = AW + 1;
  localparam int SQW = 2 * DW;
  localparam int DSW = 2 * DW + 1;
  localparam int RW  = AW + 1;
  localparam int STW = $clog2(SW + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_CLASSIFY, S_DRAIN, S_UPDATE, S_CHECK, S_DONE
  } state_t;

  state_t         state;
  logic [DW-1:0]  cen0 [K];
  logic [DW-1:0]  cen1 [K];
  logic [SW-1:0]  sum0 [K];
  logic [SW-1:0]  sum1 [K];
  logic [CW-1:0]  cnt  [K];

  logic           s1_v, s2_v, s3_v, s4_v;
  logic [DW-1:0]  s1_d0, s1_d1, s2_d0, s2_d1, s3_d0, s3_d1, s4_d0, s4_d1;
  logic [DW-1:0]  s1_a0 [K];
  logic [DW-1:0]  s1_a1 [K];
  logic [SQW-1:0] s2_q0 [K];
  logic [SQW-1:0] s2_q1 [K];
  logic [DSW-1:0] s3_dist [K];
  logic [2:0]     s4_idx;

  logic [1:0]     drain_cnt;
  logic [2:0]     upd_k;
  logic [STW-1:0] div_step;
  logic [SW-1:0]  dq0, dq1;
  logic [RW-1:0]  dr0, dr1;
  logic [CW-1:0]  dvs;
`ifdef KMEANS_CONV_EN
  logic           changed;
`endif

  logic [2:0]     best_idx;
  logic [DSW-1:0] best_dist;
  logic [SW-1:0]  sel_sum0, sel_sum1;
  logic [CW-1:0]  sel_cnt;
  logic [DW-1:0]  sel_c0, sel_c1;
  logic [RW:0]    sh0, sh1, nr0, nr1;
  logic           ge0, ge1;
  logic [SW-1:0]  nq0, nq1;

  assign state_dbg = state;

  always_comb begin
    c_d0 = '0;
    c_d1 = '0;
    for (int i = 0; i < K; i++) begin
      if (rd_idx == 3'(i)) begin
        c_d0 = cen0[i];
        c_d1 = cen1[i];
      end
    end
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    best_idx  = '0;
    best_dist = s3_dist[0];
    for (int i = 1; i < K; i++) begin
      if (s3_dist[i] < best_dist) begin
        best_dist = s3_dist[i];
        best_idx  = 3'(i);
      end
    end
  end

  always_comb begin
    sel_sum0 = '0;
    sel_sum1 = '0;
    sel_cnt  = '0;
    sel_c0   = '0;
    sel_c1   = '0;
    for (int i = 0; i < K; i++) begin
      if (upd_k == 3'(i)) begin
        sel_sum0 = sum0[i];
        sel_sum1 = sum1[i];
        sel_cnt  = cnt[i];
        sel_c0   = cen0[i];
        sel_c1   = cen1[i];
      end
    end
  end

  // One restoring-division step per dimension; dq holds dividend, then quotient.
  always_comb begin
    sh0 = {dr0, dq0[SW-1]};
    sh1 = {dr1, dq1[SW-1]};
    ge0 = sh0 >= {1'b0, dvs};
    ge1 = sh1 >= {1'b0, dvs};
    nr0 = ge0 ? sh0 - {1'b0, dvs} : sh0;
    nr1 = ge1 ? sh1 - {1'b0, dvs} : sh1;
    nq0 = {dq0[SW-2:0], ge0};
    nq1 = {dq1[SW-2:0], ge1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s3_v <= 1'b0; s4_v <= 1'b0;
      s1_d0 <= '0; s1_d1 <= '0; s2_d0 <= '0; s2_d1 <= '0;
      s3_d0 <= '0; s3_d1 <= '0; s4_d0 <= '0; s4_d1 <= '0;
      s4_idx <= '0;
      for (int i = 0; i < K; i++) begin
        s1_a0[i] <= '0; s1_a1[i] <= '0;
        s2_q0[i] <= '0; s2_q1[i] <= '0;
        s3_dist[i] <= '0;
      end
    end else begin
      s1_v  <= (state == S_CLASSIFY);
      s1_d0 <= d0_in;
      s1_d1 <= d1_in;
      for (int i = 0; i < K; i++) begin
        s1_a0[i]   <= (d0_in >= cen0[i]) ? d0_in - cen0[i] : cen0[i] - d0_in;
        s1_a1[i]   <= (d1_in >= cen1[i]) ? d1_in - cen1[i] : cen1[i] - d1_in;
        s2_q0[i]   <= SQW'(s1_a0[i]) * SQW'(s1_a0[i]);
        s2_q1[i]   <= SQW'(s1_a1[i]) * SQW'(s1_a1[i]);
        s3_dist[i] <= DSW'(s2_q0[i]) + DSW'(s2_q1[i]);
      end
      s2_v <= s1_v; s2_d0 <= s1_d0; s2_d1 <= s1_d1;
      s3_v <= s2_v; s3_d0 <= s2_d0; s3_d1 <= s2_d1;
      s4_v <= s3_v; s4_d0 <= s3_d0; s4_d1 <= s3_d1;
      s4_idx <= best_idx;
    end
  end

  // start and ld_valid are single-cycle strobes with no ready: they are taken
  // on the clock edge only while in IDLE and silently dropped otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      converged  <= 1'b0;
      iter_count <= '0;
      data_addr  <= '0;
      drain_cnt  <= '0;
      upd_k      <= '0;
      div_step   <= '0;
      dq0 <= '0; dq1 <= '0; dr0 <= '0; dr1 <= '0; dvs <= '0;
`ifdef KMEANS_CONV_EN
      changed    <= 1'b0;
`endif
      for (int i = 0; i < K; i++) begin
        cen0[i] <= DW'(i);
        cen1[i] <= DW'(i);
        sum0[i] <= '0;
        sum1[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      if (s4_v) begin
        for (int i = 0; i < K; i++) begin
          if (s4_idx == 3'(i)) begin
            sum0[i] <= sum0[i] + SW'(s4_d0);
            sum1[i] <= sum1[i] + SW'(s4_d1);
            cnt[i]  <= cnt[i] + 1'b1;
          end
        end
      end
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (ld_valid) begin
            for (int i = 0; i < K; i++) begin
              if (ld_idx == 3'(i)) begin
                cen0[i] <= ld_d0;
                cen1[i] <= ld_d1;
              end
            end
          end
          if (start) begin
            state      <= S_CLEAR;
            busy       <= 1'b1;
            converged  <= 1'b0;
            iter_count <= '0;
          end
        end
        S_CLEAR: begin
          for (int i = 0; i < K; i++) begin
            sum0[i] <= '0;
            sum1[i] <= '0;
            cnt[i]  <= '0;
          end
`ifdef KMEANS_CONV_EN
          changed <= 1'b0;
`endif
          data_addr <= '0;
          state     <= S_CLASSIFY;
        end
        S_CLASSIFY: begin
          data_addr <= data_addr + 1'b1;
          if (data_addr == '1) begin
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == 2'd3) begin
            upd_k    <= '0;
            div_step <= '0;
            state    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (div_step == '0) begin
            dq0 <= sel_sum0;
            dq1 <= sel_sum1;
            dr0 <= '0;
            dr1 <= '0;
            dvs <= sel_cnt;
            div_step <= div_step + 1'b1;
          end else begin
            dq0 <= nq0;
            dq1 <= nq1;
            dr0 <= RW'(nr0);
            dr1 <= RW'(nr1);
            if (div_step == STW'(SW)) begin
              div_step <= '0;
              if (dvs != '0) begin
                for (int i = 0; i < K; i++) begin
                  if (upd_k == 3'(i)) begin
                    cen0[i] <= nq0[DW-1:0];
                    cen1[i] <= nq1[DW-1:0];
                  end
                end
`ifdef KMEANS_CONV_EN
                if (nq0[DW-1:0] != sel_c0 || nq1[DW-1:0] != sel_c1)
                  changed <= 1'b1;
`endif
              end
              if (upd_k == 3'(K - 1)) state <= S_CHECK;
              else upd_k <= upd_k + 1'b1;
            end else begin
              div_step <= div_step + 1'b1;
            end
          end
        end
        S_CHECK: begin
          iter_count <= iter_count + 1'b1;
`ifdef KMEANS_CONV_EN
          if (!changed) begin
            converged <= 1'b1;
            done      <= 1'b1;
            state     <= S_DONE;
          end else
`endif
          if (int'(iter_count) + 1 >= max_iter) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_CLEAR;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kmeans_kn_core.sv
// Bench for kmeans_kn_core: a K=2 convergence run and table-driven K=4 single-iteration runs.
`timescale 1ns/1ps
module tb_kmeans_kn_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a: K=2, N=4, max_iter=16
  logic       rst_a, start_a, ld_valid_a;
  logic [2:0] ld_idx_a, rd_idx_a, state_a;
  logic [7:0] ld_d0_a, ld_d1_a, d0_a, d1_a, c_d0_a, c_d1_a, iter_a;
  logic [1:0] addr_a;
  logic       busy_a, done_a, conv_a;
  logic [7:0] mem_a0 [4];
  logic [7:0] mem_a1 [4];
  assign d0_a = mem_a0[addr_a];
  assign d1_a = mem_a1[addr_a];

  // dut_b: K=4, N=4, max_iter=1
  logic       rst_b, start_b, ld_valid_b;
  logic [2:0] ld_idx_b, rd_idx_b, state_b;
  logic [7:0] ld_d0_b, ld_d1_b, d0_b, d1_b, c_d0_b, c_d1_b, iter_b;
  logic [1:0] addr_b;
  logic       busy_b, done_b, conv_b;
  logic [7:0] mem_b0 [4];
  logic [7:0] mem_b1 [4];
  assign d0_b = mem_b0[addr_b];
  assign d1_b = mem_b1[addr_b];

  kmeans_kn_core #(.K(2), .data_width(8), .n_input_data_b_depth(2),
                   .acc_sum_width(16), .max_iter(16)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .ld_valid(ld_valid_a), .ld_idx(ld_idx_a),
    .ld_d0(ld_d0_a), .ld_d1(ld_d1_a), .data_addr(addr_a), .d0_in(d0_a), .d1_in(d1_a),
    .rd_idx(rd_idx_a), .c_d0(c_d0_a), .c_d1(c_d1_a), .busy(busy_a), .done(done_a),
    .converged(conv_a), .iter_count(iter_a), .state_dbg(state_a));

  kmeans_kn_core #(.K(4), .data_width(8), .n_input_data_b_depth(2),
                   .acc_sum_width(16), .max_iter(1)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .ld_valid(ld_valid_b), .ld_idx(ld_idx_b),
    .ld_d0(ld_d0_b), .ld_d1(ld_d1_b), .data_addr(addr_b), .d0_in(d0_b), .d1_in(d1_b),
    .rd_idx(rd_idx_b), .c_d0(c_d0_b), .c_d1(c_d1_b), .busy(busy_b), .done(done_b),
    .converged(conv_b), .iter_count(iter_b), .state_dbg(state_b));

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    string            name;
    logic [3:0][7:0]  p0, p1, c0, c1, e0, e1;
    logic             chk_conv;
  } vec_t;
  vec_t vecs[4];

  function automatic logic [3:0][7:0] q4(input logic [7:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload_b(input logic [3:0][7:0] c0, input logic [3:0][7:0] c1);
    for (int i = 0; i < 4; i++) begin
      ld_valid_b = 1'b1;
      ld_idx_b   = 3'(i);
      ld_d0_b    = c0[i];
      ld_d1_b    = c1[i];
      tick();
    end
    ld_valid_b = 1'b0;
  endtask

  task automatic load_a(input logic [2:0] idx, input logic [7:0] v0, input logic [7:0] v1);
    ld_valid_a = 1'b1;
    ld_idx_a   = idx;
    ld_d0_a    = v0;
    ld_d1_a    = v1;
    tick();
    ld_valid_a = 1'b0;
  endtask

  task automatic wait_done_b();
    int n = 0;
    while (!done_b && n < 2000) begin
      tick();
      n++;
    end
    if (!done_b) check("done_b timeout", 0, 1);
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (!done_a && n < 3000) begin
      tick();
      n++;
    end
    if (!done_a) check("done_a timeout", 0, 1);
  endtask

  task automatic compare_a(input string tag);
    for (int i = 0; i < 2; i++) begin
      rd_idx_a = 3'(i);
      #1;
      check($sformatf("%s c%0d.d0", tag, i), c_d0_a, exp_q.pop_front());
      check($sformatf("%s c%0d.d1", tag, i), c_d1_a, exp_q.pop_front());
    end
  endtask

  task automatic run_vec_b(input int v);
    for (int i = 0; i < 4; i++) begin
      mem_b0[i] = vecs[v].p0[i];
      mem_b1[i] = vecs[v].p1[i];
    end
    preload_b(vecs[v].c0, vecs[v].c1);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(vecs[v].e0[i]);
      exp_q.push_back(vecs[v].e1[i]);
    end
    exp_q.push_back(8'd1);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    wait_done_b();
    for (int i = 0; i < 4; i++) begin
      rd_idx_b = 3'(i);
      #1;
      check($sformatf("%s c%0d.d0", vecs[v].name, i), c_d0_b, exp_q.pop_front());
      check($sformatf("%s c%0d.d1", vecs[v].name, i), c_d1_b, exp_q.pop_front());
    end
    check($sformatf("%s iter", vecs[v].name), iter_b, exp_q.pop_front());
    if (vecs[v].chk_conv) check($sformatf("%s converged", vecs[v].name), conv_b, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{"empty", q4(10,10,10,10), q4(10,10,10,10),
                q4(10,50,90,130), q4(10,50,90,130), q4(10,50,90,130), q4(10,50,90,130), 1'b0};
    vecs[1] = '{"tie", q4(5,200,200,200), q4(5,200,200,200),
                q4(0,10,100,200), q4(0,10,100,200), q4(5,10,100,200), q4(5,10,100,200), 1'b1};
    vecs[2] = '{"floor", q4(1,2,250,251), q4(7,8,3,4),
                q4(0,255,128,0), q4(0,0,128,255), q4(1,250,128,0), q4(7,3,128,255), 1'b1};
    vecs[3] = '{"high", q4(255,254,255,252), q4(255,254,253,255),
                q4(0,1,2,200), q4(0,1,2,200), q4(0,1,2,254), q4(0,1,2,254), 1'b1};

    rst_a = 1'b0; rst_b = 1'b0;
    start_a = 1'b0; ld_valid_a = 1'b0; ld_idx_a = '0; ld_d0_a = '0; ld_d1_a = '0; rd_idx_a = '0;
    start_b = 1'b0; ld_valid_b = 1'b0; ld_idx_b = '0; ld_d0_b = '0; ld_d1_b = '0; rd_idx_b = '0;
    for (int i = 0; i < 4; i++) begin
      mem_a0[i] = '0; mem_a1[i] = '0; mem_b0[i] = '0; mem_b1[i] = '0;
    end
    tick(); tick();
    rst_a = 1'b1; rst_b = 1'b1;
    tick();

    // Reset values.
    check("rst busy", busy_b, 0);
    check("rst done", done_b, 0);
    check("rst converged", conv_b, 0);
    check("rst iter", iter_b, 0);
    check("rst addr", addr_b, 0);
    for (int i = 0; i < 4; i++) begin
      rd_idx_b = 3'(i);
      #1;
      check($sformatf("rst c%0d.d0", i), c_d0_b, i);
      check($sformatf("rst c%0d.d1", i), c_d1_b, i);
    end

    // Two-cluster run on dut_a; out-of-range preload indices must be dropped.
    mem_a0[0] = 0;   mem_a1[0] = 0;
    mem_a0[1] = 2;   mem_a1[1] = 2;
    mem_a0[2] = 200; mem_a1[2] = 200;
    mem_a0[3] = 202; mem_a1[3] = 202;
    load_a(3'd0, 8'd0, 8'd0);
    load_a(3'd1, 8'd255, 8'd255);
    load_a(3'd2, 8'd77, 8'd77);
    load_a(3'd4, 8'd66, 8'd66);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(255); exp_q.push_back(255);
    compare_a("preload");
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(201); exp_q.push_back(201);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (iter_a != 8'd1 && n < 500) begin
      tick();
      n++;
    end
    check("a iter1 reached", iter_a, 1);
    tick();
    compare_a("a iter1");
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(201); exp_q.push_back(201);
`ifdef KMEANS_CONV_EN
    exp_q.push_back(8'd2); exp_q.push_back(8'd1);
`else
    exp_q.push_back(8'd16); exp_q.push_back(8'd0);
`endif
    wait_done_a();
    compare_a("a final");
    check("a iter_count", iter_a, exp_q.pop_front());
    check("a converged", conv_a, exp_q.pop_front());
    tick();

    // Table-driven single-iteration runs on dut_b.
    for (int v = 0; v < 4; v++) run_vec_b(v);

    // Iteration cap, exact latency, address walk and start-while-busy.
    for (int i = 0; i < 4; i++) begin
      mem_b0[i] = vecs[1].p0[i];
      mem_b1[i] = vecs[1].p1[i];
    end
    preload_b(vecs[1].c0, vecs[1].c1);
    start_b = 1'b1;
    n = 0;
    while (!done_b && n < 500) begin
      tick();
      n++;
      if (n == 1) start_b = 1'b0;
      if (n == 2) check("cap addr c2", addr_b, 0);
      if (n == 3) check("cap addr c3", addr_b, 1);
      if (n == 5) check("cap addr c5", addr_b, 3);
      if (n == 6) check("cap addr c6", addr_b, 0);
      if (n == 20) start_b = 1'b1;
      if (n == 21) start_b = 1'b0;
    end
    check("cap done latency", n, 79);
    check("cap iter", iter_b, 1);
    check("cap converged", conv_b, 0);
    check("cap busy at done", busy_b, 1);
    tick();
    check("cap busy after", busy_b, 0);
    check("cap done after", done_b, 0);
    for (int i = 0; i < 5; i++) tick();
    check("cap no restart", busy_b, 0);

    // Asynchronous reset in the middle of CLASSIFY.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick(); tick();
    check("mid busy", busy_b, 1);
    check("mid addr", addr_b, 1);
    rst_b = 1'b0;
    #1;
    rd_idx_b = 3'd3;
    #1;
    check("async busy", busy_b, 0);
    check("async addr", addr_b, 0);
    check("async c3.d0", c_d0_b, 3);
    check("async c3.d1", c_d1_b, 3);
    tick();
    rst_b = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
